sha256_msg_padder: RTL

- Upstream stage of the SHA-256 datapath, feeding the message scheduler.
- Accepts the raw message as a stream of 32-bit big-endian words with a byte count on the final beat.
- Applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit message bit-length.
- Emits complete 512-bit blocks over a valid/ready handshake; block_out and block_valid connect to the scheduler's block_in and input_valid.

---
 rtl/sha256_pkg.sv | 21 ++
 rtl/sha256_pad_word.sv | 28 ++
 rtl/sha256_msg_padder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and state type for the SHA-256 message padding stage.
package sha256_pkg;

  localparam int BLOCK_W         = 512;
  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int LEN_WORD_HI     = 14;
  localparam int LEN_WORD_LO     = 15;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Word w of a block lives at packed index (LAST_IDX - w), so word 0 is the MSBs.
  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    COLLECT,
    PAD,
    EMIT,
    EXTRA
  } pad_state_e;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks the unused bytes of the final message word and drops the 0x80 marker
// right after the last valid byte. A full word leaves no room, which is flagged.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] word_in,
  input  logic [2:0]        byte_cnt,
  output logic [WORD_W-1:0] word_out,
  output logic              pad_spill
);

  // Select the padded word shape from the count of valid leading bytes.
  always_comb begin
    word_out  = word_in;
    pad_spill = 1'b0;
    case (byte_cnt)
      3'd0:    word_out = {PAD_BYTE, 24'h000000};
      3'd1:    word_out = {word_in[31:24], PAD_BYTE, 16'h0000};
      3'd2:    word_out = {word_in[31:16], PAD_BYTE, 8'h00};
      3'd3:    word_out = {word_in[31:8], PAD_BYTE};
      default: begin
        word_out  = word_in;
        pad_spill = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Collects 32-bit message words into 512-bit blocks, applies SHA-256 padding
// (0x80, zero fill, 64-bit bit length) and hands blocks downstream.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               data_valid,
  input  logic               data_last,
  input  logic [2:0]         data_bytes,
  output logic               data_ready,
  output logic [BLOCK_W-1:0] block_out,
  output logic               block_valid,
  input  logic               block_ready,
  output logic               block_first,
  output logic               block_last
);

  pad_state_e                           state_q, state_d;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] blk_q, blk_d;
  logic [3:0]                           idx_q, idx_d;
  logic [LEN_W-1:0]                     length_q, length_d;
  logic [2:0]                           last_bytes_q, last_bytes_d;
  logic                                 first_pend_q, first_pend_d;
  logic                                 extra_q, extra_d;
  logic                                 placed_q, placed_d;
  logic                                 block_last_q, block_last_d;
  logic                                 block_first_q, block_first_d;
  logic                                 block_valid_q, block_valid_d;
  logic                                 data_ready_q, data_ready_d;

  logic                                 accept;
  logic [2:0]                           eff_bytes;
  logic [WORD_W-1:0]                    padded_word;
  logic                                 pad_spill;
  logic [4:0]                           pad_pos;

  sha256_pad_word u_pad_word (
    .word_in  (blk_q[LAST_IDX - idx_q]),
    .byte_cnt (last_bytes_q),
    .word_out (padded_word),
    .pad_spill(pad_spill)
  );

  assign accept    = data_valid && data_ready_q;
  assign eff_bytes = !data_last ? 3'd4 : ((data_bytes > 3'd4) ? 3'd4 : data_bytes);
  assign pad_pos   = {1'b0, idx_q} + {4'b0000, pad_spill};

  // Next-state logic for collecting, padding, emitting and the trailing length block.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    idx_d        = idx_q;
    length_d     = length_q;
    last_bytes_d = last_bytes_q;
    first_pend_d = first_pend_q;
    extra_d      = extra_q;
    placed_d     = placed_q;
    block_last_d = block_last_q;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          blk_d[LAST_IDX - idx_q] = data_in;
          length_d = length_q + LEN_W'({eff_bytes, 3'b000});
          if (data_last) begin
            last_bytes_d = eff_bytes;
            state_d      = PAD;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == LAST_IDX) begin
              block_last_d = 1'b0;
              state_d      = EMIT;
            end
          end
        end
      end

      PAD: begin
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
          if (i > int'(idx_q)) blk_d[LAST_IDX - 4'(i)] = '0;
        end
        blk_d[LAST_IDX - idx_q] = padded_word;
        if (pad_spill && (idx_q != LAST_IDX)) begin
          blk_d[LAST_IDX - idx_q - 4'd1] = {PAD_BYTE, 24'h000000};
        end
        placed_d = !(pad_spill && (idx_q == LAST_IDX));
        if (pad_pos < 5'(LEN_WORD_HI)) begin
          blk_d[LAST_IDX - 4'(LEN_WORD_HI)] = length_q[LEN_W-1 -: WORD_W];
          blk_d[LAST_IDX - 4'(LEN_WORD_LO)] = length_q[WORD_W-1:0];
          block_last_d = 1'b1;
          extra_d      = 1'b0;
        end else begin
          block_last_d = 1'b0;
          extra_d      = 1'b1;
        end
        state_d = EMIT;
      end

      EMIT: begin
        if (block_ready) begin
          idx_d = 4'd0;
          if (extra_q) begin
            first_pend_d = 1'b0;
            extra_d      = 1'b0;
            state_d      = EXTRA;
          end else if (block_last_q) begin
            length_d     = '0;
            first_pend_d = 1'b1;
            block_last_d = 1'b0;
            state_d      = COLLECT;
          end else begin
            first_pend_d = 1'b0;
            state_d      = COLLECT;
          end
        end
      end

      EXTRA: begin
        blk_d = '0;
        if (!placed_q) blk_d[LAST_IDX] = {PAD_BYTE, 24'h000000};
        blk_d[LAST_IDX - 4'(LEN_WORD_HI)] = length_q[LEN_W-1 -: WORD_W];
        blk_d[LAST_IDX - 4'(LEN_WORD_LO)] = length_q[WORD_W-1:0];
        block_last_d = 1'b1;
        placed_d     = 1'b1;
        state_d      = EMIT;
      end

      default: state_d = COLLECT;
    endcase

    data_ready_d  = (state_d == COLLECT);
    block_valid_d = (state_d == EMIT);
    block_first_d = (state_d == EMIT) && first_pend_d;
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      blk_q         <= '0;
      idx_q         <= '0;
      length_q      <= '0;
      last_bytes_q  <= '0;
      first_pend_q  <= 1'b1;
      extra_q       <= 1'b0;
      placed_q      <= 1'b1;
      block_last_q  <= 1'b0;
      block_first_q <= 1'b0;
      block_valid_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      blk_q         <= blk_d;
      idx_q         <= idx_d;
      length_q      <= length_d;
      last_bytes_q  <= last_bytes_d;
      first_pend_q  <= first_pend_d;
      extra_q       <= extra_d;
      placed_q      <= placed_d;
      block_last_q  <= block_last_d;
      block_first_q <= block_first_d;
      block_valid_q <= block_valid_d;
      data_ready_q  <= data_ready_d;
    end
  end

  assign data_ready  = data_ready_q;
  assign block_out   = blk_q;
  assign block_valid = block_valid_q;
  assign block_first = block_first_q;
  assign block_last  = block_last_q;

endmodule
